// File: rtl/npu_cube_pkg.sv
// Shared widths and FSM state encoding for the NPU cube accumulator.
package npu_cube_pkg;
    localparam int DWIN  = 19;
    localparam int DWACC = 32;
    localparam int DWOUT = 16;
    localparam int DWLEN = 8;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
endpackage

// File: rtl/npu_cube_acc_sat.sv
// Clamps the wide accumulator into the output range; res = {sat_flag, data}.
module npu_cube_acc_sat #(
    parameter int DWACC = 32,
    parameter int DWOUT = 16
) (
    input  logic [DWACC-1:0] acc,
    input  logic             is_signed,
    output logic [DWOUT:0]   res
);
    localparam logic [DWACC-1:0] SMAX = {{(DWACC-DWOUT+1){1'b0}}, {(DWOUT-1){1'b1}}};
    localparam logic [DWACC-1:0] SMIN = ~SMAX;
    localparam logic [DWACC-1:0] UMAX = {{(DWACC-DWOUT){1'b0}}, {DWOUT{1'b1}}};

    always_comb begin
        res = {1'b0, acc[DWOUT-1:0]};
        if (is_signed) begin
            if ($signed(acc) > $signed(SMAX))
                res = {1'b1, SMAX[DWOUT-1:0]};
            else if ($signed(acc) < $signed(SMIN))
                res = {1'b1, SMIN[DWOUT-1:0]};
        end else if (acc > UMAX) begin
            // an unsigned group can only overflow upward
            res = {1'b1, UMAX[DWOUT-1:0]};
        end
    end
endmodule

// File: rtl/npu_cube_accumulator.sv
// Accumulates groups of add-tree partial results and hands one result per group downstream.
// Optional output clamping is enabled with `define NPU_CUBE_ACC_SAT_EN.
module npu_cube_accumulator
    import npu_cube_pkg::*;
#(
    parameter int DWIN  = npu_cube_pkg::DWIN,
    parameter int DWACC = npu_cube_pkg::DWACC,
    parameter int DWOUT = npu_cube_pkg::DWOUT,
    parameter int DWLEN = npu_cube_pkg::DWLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DWIN-1:0]  in_result,
    input  logic             is_signed,
    input  logic [DWLEN-1:0] acc_len_m1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DWOUT-1:0] out_data,
    output logic             out_sat
);
    state_t           state, state_nx;
    logic [DWACC-1:0] acc;
    logic [DWLEN-1:0] cnt, len_q, cnt_inc;
    logic             sgn_q;
    logic             beat, otx, first;

    function automatic logic [DWACC-1:0] ext(input logic [DWIN-1:0] x, input logic s);
        return s ? {{(DWACC-DWIN){x[DWIN-1]}}, x} : {{(DWACC-DWIN){1'b0}}, x};
    endfunction

    assign beat    = in_valid && in_ready;
    assign otx     = out_valid && out_ready;
    assign cnt_inc = cnt + 1'b1;
    // outside ACC any accepted beat opens a new group (in HOLD it pairs with the output transfer)
    assign first   = (state != ACC);

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (beat) state_nx = (acc_len_m1 == '0) ? HOLD : ACC;
            end
            ACC: begin
                in_ready = !rst;
                if (beat && cnt_inc == len_q) state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst;
                if (otx) begin
                    if (beat) state_nx = (acc_len_m1 == '0) ? HOLD : ACC;
                    else      state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            sgn_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (beat) begin
                if (first) begin
                    acc   <= ext(in_result, is_signed);
                    len_q <= acc_len_m1;
                    sgn_q <= is_signed;
                    cnt   <= '0;
                end else begin
                    acc <= acc + ext(in_result, sgn_q);
                    cnt <= cnt_inc;
                end
            end
        end
    end

`ifdef NPU_CUBE_ACC_SAT_EN
    npu_cube_acc_sat #(
        .DWACC (DWACC),
        .DWOUT (DWOUT)
    ) u_sat (
        .acc       (acc),
        .is_signed (sgn_q),
        .res       ({out_sat, out_data})
    );
`else
    assign out_data = acc[DWOUT-1:0];
    assign out_sat  = 1'b0;
`endif
endmodule

// File: tb/tb_npu_cube_accumulator.sv
// Self-checking bench for npu_cube_accumulator: directed scenarios plus a randomized run against a group-level model.
module tb_npu_cube_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_result;
    logic        is_signed;
    logic [7:0]  acc_len_m1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    npu_cube_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .is_signed  (is_signed),
        .acc_len_m1 (acc_len_m1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat)
    );

    // Expected {sat, data} for a group whose exact arithmetic sum is 'sum'.
    function automatic logic [16:0] model_out(input longint sum, input bit sgn);
        logic [16:0] r;
        r = {1'b0, sum[15:0]};
`ifdef NPU_CUBE_ACC_SAT_EN
        if (sgn) begin
            if (sum > 32767)       r = {1'b1, 16'h7FFF};
            else if (sum < -32768) r = {1'b1, 16'h8000};
        end else if (sum > 65535) begin
            r = {1'b1, 16'hFFFF};
        end
`endif
        return r;
    endfunction

    function automatic longint ext_val(input logic [18:0] x, input bit sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    // Drive inputs mid-cycle, settle, then the caller samples before the next rising edge.
    task automatic set_in(input bit v, input int data, input bit sgn, input int len, input bit ordy);
        @(negedge clk);
        in_valid   = v;
        in_result  = 19'(data);
        is_signed  = sgn;
        acc_len_m1 = 8'(len);
        out_ready  = ordy;
        #1;
    endtask

    task automatic chk_out(input string nm, input bit ov, input longint sum, input bit sgn);
        logic [16:0] e;
        e = model_out(sum, sgn);
        total++;
        if (out_valid !== ov) begin
            bad++;
            $display("FAIL %s out_valid got=%b exp=%b", nm, out_valid, ov);
        end
        if (ov) begin
            total++;
            if ({out_sat, out_data} !== e) begin
                bad++;
                $display("FAIL %s data got=%b/%h exp=%b/%h", nm, out_sat, out_data, e[16], e[15:0]);
            end
        end
    endtask

    task automatic chk_rdy(input string nm, input bit exp);
        total++;
        if (in_ready !== exp) begin
            bad++;
            $display("FAIL %s in_ready got=%b exp=%b", nm, in_ready, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_rdy("rst_ready", 1'b0);
        total++;
        if ({out_valid, out_sat, out_data} !== 18'd0) begin
            bad++;
            $display("FAIL rst_outputs got=%b%b%h exp=0", out_valid, out_sat, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_rdy("rst_release_ready", 1'b1);
        chk_out("rst_release_ov", 1'b0, 0, 0);
    endtask

    task automatic test_signed_basic();
        int beats[4] = '{100, -50, 7, 1};
        for (int i = 0; i < 4; i++) begin
            set_in(1, beats[i], 1, 3, 1);
            chk_out($sformatf("sb_beat%0d", i), 1'b0, 0, 1);
            @(posedge clk);
        end
        set_in(0, 0, 0, 0, 1);
        chk_out("sb_result", 1'b1, 58, 1);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("sb_single_pulse", 1'b0, 0, 1);
    endtask

    task automatic test_len0_b2b();
        set_in(1, 5, 0, 0, 1);
        @(posedge clk);
        set_in(1, 9, 0, 0, 1);
        chk_out("l0_first", 1'b1, 5, 0);
        chk_rdy("l0_b2b_ready", 1'b1);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("l0_second", 1'b1, 9, 0);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("l0_drained", 1'b0, 0, 0);
    endtask

    task automatic test_stall();
        set_in(1, 10, 1, 1, 1);
        @(posedge clk);
        set_in(1, 20, 1, 1, 1);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            set_in(1, 77, 1, 0, 0);
            chk_out($sformatf("stall_hold%0d", i), 1'b1, 30, 1);
            chk_rdy($sformatf("stall_ready%0d", i), 1'b0);
            @(posedge clk);
        end
        set_in(0, 0, 0, 0, 1);
        chk_out("stall_release", 1'b1, 30, 1);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("stall_done", 1'b0, 0, 1);
    endtask

    task automatic test_sat();
        set_in(1, 262143, 1, 1, 1);
        @(posedge clk);
        set_in(1, 262143, 1, 1, 1);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("sat_pos", 1'b1, 524286, 1);
        @(posedge clk);
        set_in(1, -262144, 1, 1, 1);
        @(posedge clk);
        set_in(1, -262144, 1, 1, 1);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("sat_neg", 1'b1, -524288, 1);
        @(posedge clk);
    endtask

    task automatic test_ext();
        set_in(1, 'h7FFFF, 0, 0, 1);
        @(posedge clk);
        set_in(1, 'h7FFFF, 1, 0, 1);
        chk_out("ext_unsigned", 1'b1, 524287, 0);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("ext_signed", 1'b1, -1, 1);
        @(posedge clk);
        // signedness is taken from the first beat only
        set_in(1, 'h7FFFF, 0, 1, 1);
        @(posedge clk);
        set_in(1, 'h7FFFF, 1, 1, 1);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("ext_latched", 1'b1, 1048574, 0);
        @(posedge clk);
    endtask

    task automatic test_reset_midgroup();
        set_in(1, 1000, 0, 3, 1);
        @(posedge clk);
        set_in(1, 2000, 0, 3, 1);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        rst = 1'b1;
        #1;
        chk_rdy("rmg_ready_in_rst", 1'b0);
        @(posedge clk);
        set_in(1, 3, 0, 1, 1);
        rst = 1'b0;
        #1;
        chk_out("rmg_no_out", 1'b0, 0, 0);
        chk_rdy("rmg_ready_after", 1'b1);
        @(posedge clk);
        set_in(1, 4, 0, 1, 1);
        chk_out("rmg_mid", 1'b0, 0, 0);
        @(posedge clk);
        set_in(0, 0, 0, 0, 1);
        chk_out("rmg_fresh", 1'b1, 7, 0);
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [16:0] q[$];
        bit     in_grp = 0;
        bit     sgn_m  = 0;
        int     len_m  = 0;
        int     cnt_m  = 0;
        longint sum    = 0;
        for (int c = 0; c < 3000; c++) begin
            bit v, ordy, sgn, ir_exp, beat, otx;
            int data, len;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            sgn  = $urandom_range(0, 1);
            len  = $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0:       data = 'h3FFFF;
                1:       data = 'h40000;
                default: data = int'($urandom_range(0, 'h7FFFF));
            endcase
            set_in(v, data, sgn, len, ordy);
            ir_exp = (q.size() == 0) || ordy;
            total++;
            if (in_ready !== ir_exp || out_valid !== (q.size() != 0)) begin
                bad++;
                $display("FAIL rnd_hs c=%0d rdy=%b/%b ov=%b/%b", c, in_ready, ir_exp, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                total++;
                if ({out_sat, out_data} !== q[0]) begin
                    bad++;
                    $display("FAIL rnd_data c=%0d got=%b/%h exp=%b/%h", c, out_sat, out_data, q[0][16], q[0][15:0]);
                end
            end
            beat = v && ir_exp;
            otx  = (q.size() != 0) && ordy;
            if (otx) void'(q.pop_front());
            if (beat) begin
                if (!in_grp) begin
                    sgn_m = sgn; len_m = len; cnt_m = 0;
                    sum   = ext_val(19'(data), sgn);
                    in_grp = 1;
                end else begin
                    sum += ext_val(19'(data), sgn_m);
                    cnt_m++;
                end
                if (cnt_m == len_m) begin
                    q.push_back(model_out(sum, sgn_m));
                    in_grp = 0;
                end
            end
            @(posedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_result = '0; is_signed = 0; acc_len_m1 = '0; out_ready = 1;
        test_reset();
        test_signed_basic();
        test_len0_b2b();
        test_stall();
        test_sat();
        test_ext();
        test_reset_midgroup();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
